// File: rtl/rgb_mixer_multi.sv
// N-channel quadrature-encoder to PWM mixer. Inputs are debounced and decoded on a prescaler
// tick. Every channel drives one output from a shared PWM counter, and each channel's duty value is updated only at period wraps.

module rgb_mixer_ch #(
  parameter int WIDTH      = 8,
  parameter int HIST_LEN   = 8,
  parameter int STEP       = 1,
  parameter int SATURATE   = 1,
  parameter int INIT_LEVEL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick_i,
  input  logic             wrap_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             a_i,
  input  logic             b_i,
  output logic [WIDTH-1:0] level_o,
  output logic             pwm_o
);
  localparam logic [WIDTH-1:0] INIT   = WIDTH'(INIT_LEVEL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAXV   = '1;

  logic [HIST_LEN-1:0] ha_q, ha_d, hb_q, hb_d;
  logic                a_db_q, a_db_d, b_db_q, b_db_d, prev_a_q;
  logic [WIDTH-1:0]    level_q, level_d, active_q;
  logic                pwm_q;
  logic [WIDTH:0]      sum;

  always_comb begin
    ha_d   = {ha_q[HIST_LEN-2:0], a_i};
    hb_d   = {hb_q[HIST_LEN-2:0], b_i};
    a_db_d = a_db_q;
    b_db_d = b_db_q;
    if (&ha_d)       a_db_d = 1'b1;
    else if (~|ha_d) a_db_d = 1'b0;
    if (&hb_d)       b_db_d = 1'b1;
    else if (~|hb_d) b_db_d = 1'b0;
    // One extra bit: bit WIDTH set means overflow on increment or borrow on decrement
    sum     = b_db_q ? ({1'b0, level_q} - STEP_X) : ({1'b0, level_q} + STEP_X);
    level_d = level_q;
    if (!prev_a_q && a_db_q) begin
      if (sum[WIDTH] && (SATURATE != 0)) level_d = b_db_q ? '0 : MAXV;
      else                               level_d = sum[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ha_q     <= '0;
      hb_q     <= '0;
      a_db_q   <= 1'b0;
      b_db_q   <= 1'b0;
      prev_a_q <= 1'b0;
      level_q  <= INIT;
      active_q <= INIT;
      pwm_q    <= 1'b0;
    end else begin
      if (tick_i) begin
        ha_q     <= ha_d;
        hb_q     <= hb_d;
        a_db_q   <= a_db_d;
        b_db_q   <= b_db_d;
        prev_a_q <= a_db_q;
        level_q  <= level_d;
      end
      // At the wrap, the active value takes the level from before any same-tick detent
      if (wrap_i) active_q <= level_q;
      pwm_q <= (cnt_i < active_q);
    end
  end

  assign level_o = level_q;
  assign pwm_o   = pwm_q;
endmodule

module rgb_mixer_multi #(
  parameter int NUM_CH     = 3,
  parameter int WIDTH      = 8,
  parameter int DIV_BITS   = 8,
  parameter int HIST_LEN   = 8,
  parameter int STEP       = 1,
  parameter int SATURATE   = 1,
  parameter int INIT_LEVEL = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*WIDTH-1:0] level_out,
  output logic                    period_start
);
  logic [1:0][NUM_CH-1:0]       sa_q, sb_q;
  logic                         tick, wrap;
  logic [WIDTH-1:0]             cnt_q;
  logic                         period_q;
  logic [NUM_CH-1:0][WIDTH-1:0] level;

  generate
    if (DIV_BITS == 0) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_BITS-1:0] div_q;
      always_ff @(posedge clk) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_q + DIV_BITS'(1);
      end
      assign tick = &div_q;
    end
  endgenerate

  assign wrap = tick && (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sa_q     <= '0;
      sb_q     <= '0;
      cnt_q    <= '0;
      period_q <= 1'b0;
    end else begin
      sa_q     <= {sa_q[0], enc_a};
      sb_q     <= {sb_q[0], enc_b};
      if (tick) cnt_q <= cnt_q + WIDTH'(1);
      period_q <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rgb_mixer_ch #(
      .WIDTH(WIDTH), .HIST_LEN(HIST_LEN), .STEP(STEP),
      .SATURATE(SATURATE), .INIT_LEVEL(INIT_LEVEL)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .tick_i (tick),
      .wrap_i (wrap),
      .cnt_i  (cnt_q),
      .a_i    (sa_q[1][i]),
      .b_i    (sb_q[1][i]),
      .level_o(level[i]),
      .pwm_o  (pwm_out[i])
    );
  end

  assign level_out    = level;
  assign period_start = period_q;
endmodule

// File: tb/tb_rgb_mixer_multi.sv
// Bench for rgb_mixer_multi: four configurations share one stimulus stream and are
// compared against a detent-level arithmetic model and PWM duty and period counts.

module tb_rgb_mixer_multi;
  localparam int NCH  = 3;
  localparam int W    = 4;
  localparam int NDUT = 4;
  localparam int DIV  = 4;  // clks per tick with DIV_BITS=2

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NCH-1:0] enc_a = '0, enc_b = '0;
  logic [NCH-1:0]   pwm [NDUT];
  logic [NCH*W-1:0] lvl [NDUT];
  logic             ps  [NDUT];

  int checks = 0, failures = 0;
  int mlv [NDUT][NCH];

  always #5 clk = ~clk;

  rgb_mixer_multi #(.NUM_CH(NCH), .WIDTH(W), .DIV_BITS(2), .HIST_LEN(4), .STEP(1), .SATURATE(1), .INIT_LEVEL(0))
    dut0 (.clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
          .pwm_out(pwm[0]), .level_out(lvl[0]), .period_start(ps[0]));
  rgb_mixer_multi #(.NUM_CH(NCH), .WIDTH(W), .DIV_BITS(2), .HIST_LEN(4), .STEP(1), .SATURATE(0), .INIT_LEVEL(0))
    dut1 (.clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
          .pwm_out(pwm[1]), .level_out(lvl[1]), .period_start(ps[1]));
  rgb_mixer_multi #(.NUM_CH(NCH), .WIDTH(W), .DIV_BITS(2), .HIST_LEN(4), .STEP(3), .SATURATE(1), .INIT_LEVEL(0))
    dut2 (.clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
          .pwm_out(pwm[2]), .level_out(lvl[2]), .period_start(ps[2]));
  rgb_mixer_multi #(.NUM_CH(NCH), .WIDTH(W), .DIV_BITS(2), .HIST_LEN(4), .STEP(3), .SATURATE(0), .INIT_LEVEL(0))
    dut3 (.clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b),
          .pwm_out(pwm[3]), .level_out(lvl[3]), .period_start(ps[3]));

  function automatic int step_of(int d);
    return (d < 2) ? 1 : 3;
  endfunction

  function automatic bit sat_of(int d);
    return (d % 2) == 0;
  endfunction

  // One detent applied to a level: plain integer add/sub, then clamp or modulo 16
  function automatic int apply(int d, int lv, bit down);
    int r;
    r = down ? lv - step_of(d) : lv + step_of(d);
    if (sat_of(d)) r = (r < 0) ? 0 : ((r > 15) ? 15 : r);
    else           r = ((r % 16) + 16) % 16;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_levels(input string tag);
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH; c++)
        chk($sformatf("%s lvl d%0d ch%0d", tag, d, c), 32'(lvl[d][c*W +: W]), 32'(mlv[d][c]));
  endtask

  // Reset for one clk, check the reset state, then time the first period_start
  task automatic do_reset(input string tag);
    int n;
    @(negedge clk);
    enc_a = '0; enc_b = '0; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      for (int c = 0; c < NCH; c++) mlv[d][c] = 0;
      chk($sformatf("%s rst pwm d%0d", tag, d), 32'(pwm[d]), 32'd0);
      chk($sformatf("%s rst ps d%0d", tag, d), 32'(ps[d]), 32'd0);
    end
    check_levels({tag, " rst"});
    n = 0;
    do begin @(negedge clk); n++; end while (ps[0] !== 1'b1 && n < 300);
    chk({tag, " first period clks"}, n, 64);
    for (int d = 1; d < NDUT; d++) chk($sformatf("%s ps align d%0d", tag, d), 32'(ps[d]), 32'd1);
  endtask

  // From one period_start, count pwm-high clks over the following full period
  task automatic measure_pwm(input string tag);
    int n, pc;
    int hi [NDUT][NCH];
    for (int d = 0; d < NDUT; d++) for (int c = 0; c < NCH; c++) hi[d][c] = 0;
    n = 0; pc = 0;
    do begin @(negedge clk); n++; end while (ps[0] !== 1'b1 && n < 300);
    chk({tag, " period found"}, 32'(n < 300), 32'd1);
    for (int k = 0; k < 16 * DIV; k++) begin
      @(negedge clk);
      pc += int'(ps[0]);
      for (int d = 0; d < NDUT; d++) for (int c = 0; c < NCH; c++) hi[d][c] += int'(pwm[d][c]);
    end
    chk({tag, " one ps per period"}, pc, 1);
    chk({tag, " ps at period end"}, 32'(ps[0]), 32'd1);
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH; c++)
        chk($sformatf("%s duty d%0d ch%0d", tag, d, c), hi[d][c], DIV * mlv[d][c]);
  endtask

  // Lower A and set B, let it settle, then raise A on the firing channels
  task automatic detent_step(input logic [NCH-1:0] fire, input logic [NCH-1:0] down, input bit bounce0);
    @(negedge clk);
    enc_a = '0; enc_b = down;
    repeat (40) @(negedge clk);
    if (bounce0 && fire[0]) begin
      enc_a[0] = 1'b1; repeat (DIV) @(negedge clk);
      enc_a[0] = 1'b0; repeat (DIV) @(negedge clk);
    end
    enc_a = fire;
    repeat (40) @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      for (int c = 0; c < NCH; c++)
        if (fire[c]) mlv[d][c] = apply(d, mlv[d][c], down[c]);
  endtask

  initial begin
    logic [NCH-1:0] f, dn;
    bit             bn;
    repeat (3) @(negedge clk);
    do_reset("init");
    measure_pwm("idle");

    for (int i = 0; i < 5; i++) begin
      detent_step(3'b001, 3'b000, 1'b0);
      check_levels($sformatf("ch0 up%0d", i));
    end
    measure_pwm("ch0 five");

    for (int i = 0; i < 3; i++) begin
      detent_step(3'b010, 3'b010, 1'b0);
      check_levels($sformatf("ch1 dn%0d", i));
    end

    for (int i = 0; i < 20; i++) detent_step(3'b100, 3'b000, 1'b0);
    check_levels("ch2 up20");
    measure_pwm("ch2 full");

    detent_step(3'b001, 3'b000, 1'b1);
    check_levels("bounce");

    for (int i = 0; i < 10; i++) begin
      f  = NCH'($urandom);
      dn = NCH'($urandom);
      bn = 1'($urandom);
      detent_step(f, dn, bn);
      check_levels($sformatf("rand%0d", i));
    end
    measure_pwm("rand");

    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (ps[0] !== 1'b1 && n < 300);
      chk("midrst sync", 32'(n < 300), 32'd1);
      repeat (20) @(negedge clk);
    end
    do_reset("midrst");
    measure_pwm("post rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rgb_mixer_multi.md
Name: rgb_mixer_multi

Overview:
Parametrised N-channel encoder-to-PWM mixer: the next generation of the three-channel RGB mixer top level.
- Single clock domain; a prescaler clock-enable (tick) replaces the divided clock.
- Per-channel input debounce, x1 quadrature decode, configurable step, saturate-or-wrap level counter.
- Shared-counter PWM with a glitch-free level update at each period boundary.
- Self-contained: all logic is inline; existing debounce/encoder/pwm submodules are not instantiated, because their timing differs.

Parameters:
NUM_CH, 3, number of encoder/PWM channels (1..16)
WIDTH, 8, level and PWM counter width in bits (2..16)
DIV_BITS, 8, prescaler width; tick every 2^DIV_BITS clk cycles; 0 means tick every cycle
HIST_LEN, 8, debounce history length in ticks (2..32)
STEP, 1, level change per detent (1..2^WIDTH-1)
SATURATE, 1, 1 = clamp level at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH
INIT_LEVEL, 0, level value loaded on reset

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enc_a  input  NUM_CH  encoder A phase, bit i = channel i, asynchronous raw input
enc_b  input  NUM_CH  encoder B phase, bit i = channel i, asynchronous raw input
pwm_out  output  NUM_CH  PWM output per channel
level_out  output  NUM_CH*WIDTH  current encoder level, channel i at bits [i*WIDTH +: WIDTH]
period_start  output  1  one-clk pulse when the shared PWM counter wraps to 0

Behaviour:
Reset (reset_n low at a clk rising edge):
- Prescaler, sync flops, debounce histories, debounced values, previous-A registers, PWM counter: all 0.
- Level registers and active PWM levels: INIT_LEVEL.
- pwm_out = 0, period_start = 0.
- Reset mid-operation aborts everything the same way; no partial state survives.

Input synchronisation:
- Two-flop synchroniser on every enc_a/enc_b bit, clocked every clk, independent of tick.

Prescaler:
- DIV_BITS-bit counter, increments each clk.
- tick = 1 for one clk when the counter equals all-ones; the counter then wraps to 0.
- First tick occurs 2^DIV_BITS clks after reset release.
- DIV_BITS = 0: tick is constant 1 out of reset.

Debounce (per synced input, on tick only):
- Shift the synced bit into a HIST_LEN history.
- History all ones -> debounced = 1; all zeros -> debounced = 0; otherwise hold.
- Latency: a clean edge appears on the debounced value HIST_LEN ticks after the synced input changes.

Quadrature decode (per channel, on tick only):
- prev_a <= a_db each tick.
- Detent = prev_a == 0 and a_db == 1.
- On a detent: b_db == 0 -> increment by STEP; b_db == 1 -> decrement by STEP.
- Arithmetic is done at WIDTH+1 bits.
- SATURATE = 1: result > 2^WIDTH-1 clamps to 2^WIDTH-1; result < 0 clamps to 0.
- SATURATE = 0: keep the low WIDTH bits.
- Channels are fully independent; simultaneous detents on several channels all apply in the same tick.
- level_out reflects the level registers directly; it updates the clk after the detent tick.

PWM:
- Shared WIDTH-bit counter cnt, +1 per tick, wraps 2^WIDTH-1 -> 0.
- On the tick where cnt wraps to 0: copy every level register into its active level, and pulse period_start for that one clk.
- A detent on that same tick loads the pre-update level; the new level takes effect next period.
- pwm_out[i] = registered (cnt < active_level[i]), updated every clk.
- Active level 0: output always 0. Active level 2^WIDTH-1: high 2^WIDTH-1 of 2^WIDTH ticks.
- Active level never changes mid-period, so there are no runt pulses.

Test Plan:
(Unless stated: NUM_CH=3, WIDTH=4, DIV_BITS=2, HIST_LEN=4, STEP=1, SATURATE=1, INIT_LEVEL=0.)
1. Reset, hold inputs low, run 200 clks -> pwm_out = 0, level_out = 0, period_start pulses every 64 clks (16 ticks x 4).
2. Ch0: set b = 0, then raise a, hold both stable 40 clks; repeat 5 detents -> level_out[3:0] = 5; pwm_out[0] high exactly 5 of every 16 ticks, starting at the period after the change.
3. Ch1 at 0: apply 3 detents with b = 1 -> level stays 0 (saturate). Same with SATURATE=0 -> levels 15, 14, 13.
4. Ch2: 20 up-detents with STEP=3, SATURATE=1 -> level 15, PWM high 15 of 16 ticks. With SATURATE=0 -> (20*3) mod 16 = 12.
5. Ch0: a toggles every tick for 3 ticks (bounce shorter than HIST_LEN), then settles high -> exactly one increment; ch1 and ch2 unchanged.
6. Assert reset_n low for one clk mid-period with levels 5, 7, 9 -> next clk all outputs 0, levels = INIT_LEVEL, prescaler restarts (first tick 4 clks later).
